// File: rtl/sdram_tst_pkg.sv
// rtl/sdram_tst_pkg.sv - shared widths and state encodings for the SDRAM test responder
package sdram_tst_pkg;

  localparam int ADDR_W  = 25;
  localparam int DOUT_W  = 16;
  localparam int LDOUT_W = 32;
  localparam int DIN_W   = 8;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_WAIT = 3'd1;
  localparam logic [2:0] ST_RD   = 3'd2;
  localparam logic [2:0] ST_WR   = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

endpackage

// File: rtl/sdram_resp_ram.sv
// rtl/sdram_resp_ram.sv - single-port synchronous byte RAM backing the responder
// Ports: CLK clock; addr byte address; we write enable; wdata write byte;
//        rdata registered read byte (one cycle after addr).
module sdram_resp_ram #(
  parameter int AW = 12
) (
  input  logic          CLK,
  input  logic [AW-1:0] addr,
  input  logic          we,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);

  logic [7:0] mem [0:(1<<AW)-1];

  always_ff @(posedge CLK) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/sdram_resp_model.sv
// rtl/sdram_resp_model.sv - SDRAM test-client port responder backed by a byte RAM
// Ports: CLK clock; RESET async active-high reset;
//        sdram_addr/sdram_din/sdram_rnw request fields sampled at accept;
//        sdram_req request level; sdram_ready idle/complete flag;
//        sdram_dout/sdram_ldout word/long of last completed read;
//        req_cnt completed-transaction count; proto_err sticky protocol error.
module sdram_resp_model
  import sdram_tst_pkg::*;
#(
  parameter int AW      = 12,
  parameter int LATENCY = 3
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [ADDR_W-1:0]  sdram_addr,
  input  logic [DIN_W-1:0]   sdram_din,
  input  logic               sdram_req,
  input  logic               sdram_rnw,
  output logic               sdram_ready,
  output logic [DOUT_W-1:0]  sdram_dout,
  output logic [LDOUT_W-1:0] sdram_ldout,
  output logic [15:0]        req_cnt,
  output logic               proto_err
);

  logic [2:0]         state;
  logic [3:0]         lat_cnt;
  logic [2:0]         rd_ph;
  logic [AW-1:0]      addr_q;
  logic [DIN_W-1:0]   din_q;
  logic               rnw_q;
  logic               armed;
  logic               first_busy;
  logic [31:0]        shreg;
  logic               accept;
  logic [AW-1:0]      ram_addr;
  logic               ram_we;
  logic [7:0]         ram_q;
  logic               unused_addr_hi;

  assign unused_addr_hi = ^sdram_addr[ADDR_W-1:AW];

  assign accept      = (state == ST_IDLE) && sdram_req && armed;
  assign sdram_ready = (state == ST_IDLE);

  // Offset add is AW bits wide so a+1..a+3 wrap around the top of the RAM.
  assign ram_addr = (state == ST_RD) ? addr_q + {{(AW-2){1'b0}}, rd_ph[1:0]} : addr_q;
  assign ram_we   = (state == ST_WR);

  sdram_resp_ram #(.AW(AW)) u_ram (
    .CLK   (CLK),
    .addr  (ram_addr),
    .we    (ram_we),
    .wdata (din_q),
    .rdata (ram_q)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state       <= ST_IDLE;
      lat_cnt     <= '0;
      rd_ph       <= '0;
      addr_q      <= '0;
      din_q       <= '0;
      rnw_q       <= 1'b0;
      armed       <= 1'b1;
      first_busy  <= 1'b0;
      shreg       <= '0;
      sdram_dout  <= '0;
      sdram_ldout <= '0;
      req_cnt     <= '0;
      proto_err   <= 1'b0;
    end else begin
      if (!sdram_req) begin
        armed <= 1'b1;
      end
      // The initiator is allowed to still hold req on the first busy edge.
      first_busy <= accept;
      if ((state != ST_IDLE) && !first_busy && sdram_req) begin
        proto_err <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (accept) begin
            armed   <= 1'b0;
            addr_q  <= sdram_addr[AW-1:0];
            din_q   <= sdram_din;
            rnw_q   <= sdram_rnw;
            rd_ph   <= '0;
            lat_cnt <= 4'(LATENCY - 1);
            if (LATENCY == 0) begin
              state <= sdram_rnw ? ST_RD : ST_WR;
            end else begin
              state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (lat_cnt == 4'd0) begin
            state <= rnw_q ? ST_RD : ST_WR;
          end else begin
            lat_cnt <= lat_cnt - 4'd1;
          end
        end
        ST_RD: begin
          // Phases 0..3 issue addresses; phases 1..4 capture the byte
          // addressed one cycle earlier, so byte a lands in shreg[7:0].
          rd_ph <= rd_ph + 3'd1;
          if (rd_ph != 3'd0) begin
            shreg <= {ram_q, shreg[31:8]};
          end
          if (rd_ph == 3'd4) begin
            state <= ST_DONE;
          end
        end
        ST_WR: begin
          state <= ST_DONE;
        end
        ST_DONE: begin
          state   <= ST_IDLE;
          req_cnt <= req_cnt + 16'd1;
          if (rnw_q) begin
            sdram_dout  <= shreg[15:0];
            sdram_ldout <= shreg;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
